// File: rtl/i_mem_ctrl_if.sv
// Request/response and i_mem port bundle for the instruction memory controller.
interface i_mem_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADRS_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADRS_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_instr;
  logic                  rsp_ready;
  logic                  wr_valid;
  logic [ADRS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic [ADRS_WIDTH-5:0] mem_address;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  fetch_valid, fetch_addr, rsp_ready, wr_valid, wr_addr, wr_data, mem_q,
    output fetch_ready, rsp_valid, rsp_instr, wr_ready, mem_address, mem_wren, mem_data
  );

  modport master (
    output fetch_valid, fetch_addr, rsp_ready, wr_valid, wr_addr, wr_data, mem_q,
    input  fetch_ready, rsp_valid, rsp_instr, wr_ready, mem_address, mem_wren, mem_data
  );
endinterface

// File: rtl/i_mem_ctrl.sv
// Shares the i_mem port between instruction fetch and line writes, with a
// one-line read buffer and a write-streak guard against fetch starvation.
module i_mem_ctrl #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned ADRS_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  i_mem_ctrl_if.slave  bus
);
  localparam int unsigned LINE_W   = ADRS_WIDTH - 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t                state, state_nxt;
  logic                  buf_valid;
  logic [LINE_W-1:0]     buf_tag;
  logic [DATA_WIDTH-1:0] buf_line;
  logic [STREAK_W-1:0]   wr_streak;
  logic [LINE_W-1:0]     rd_line;
  logic [1:0]            rd_word;
  logic [WORD_W-1:0]     rsp_instr_q;
  logic [LINE_W-1:0]     last_addr;
  logic [DATA_WIDTH-1:0] last_data;

  logic [LINE_W-1:0] fetch_line, wr_line;
  logic              hit, fetch_wins, wr_grant, fetch_rdy, wr_rdy, fetch_grant;
  logic              unused_addr_bits;

  assign fetch_line       = bus.fetch_addr[ADRS_WIDTH-1:4];
  assign wr_line          = bus.wr_addr[ADRS_WIDTH-1:4];
  assign unused_addr_bits = ^{bus.fetch_addr[1:0], bus.wr_addr[3:0]};

  // Arbitration, next state and memory drive
  always_comb begin
    state_nxt       = state;
    fetch_wins      = 1'b0;
    wr_grant        = 1'b0;
    fetch_rdy       = 1'b0;
    bus.mem_wren    = 1'b0;
    bus.mem_address = last_addr;
    bus.mem_data    = last_data;
    hit             = buf_valid && (buf_tag == fetch_line);

    if (rst_n) begin
      fetch_wins = (state == IDLE) && bus.fetch_valid && !hit &&
                   (!bus.wr_valid || wr_streak == STREAK_W'(STARVE_LIMIT));
      wr_grant   = bus.wr_valid && !fetch_wins;
      fetch_rdy  = (state == IDLE) && (hit || !wr_grant);
    end
    wr_rdy      = rst_n && !fetch_wins;
    fetch_grant = bus.fetch_valid && fetch_rdy;

    unique case (state)
      IDLE:    if (fetch_grant) state_nxt = hit ? RSP : RD_WAIT;
      RD_WAIT: state_nxt = RSP;
      RSP:     if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (wr_grant) begin
      bus.mem_wren    = 1'b1;
      bus.mem_address = wr_line;
      bus.mem_data    = bus.wr_data;
    end else if (fetch_wins) begin
      bus.mem_address = fetch_line;
    end
  end

  assign bus.fetch_ready = fetch_rdy;
  assign bus.wr_ready    = wr_rdy;
  assign bus.rsp_valid   = (state == RSP);
  assign bus.rsp_instr   = rsp_instr_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Line buffer, response word, streak counter and held memory drive
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_line    <= '0;
      wr_streak   <= '0;
      rd_line     <= '0;
      rd_word     <= '0;
      rsp_instr_q <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      if (fetch_grant) begin
        rd_line <= fetch_line;
        rd_word <= bus.fetch_addr[3:2];
        if (hit) rsp_instr_q <= buf_line[{bus.fetch_addr[3:2], 5'd0} +: WORD_W];
      end

      // A write to the line in flight leaves the captured copy stale
      if (state == RD_WAIT) begin
        buf_line    <= bus.mem_q;
        buf_tag     <= rd_line;
        buf_valid   <= !(wr_grant && wr_line == rd_line);
        rsp_instr_q <= bus.mem_q[{rd_word, 5'd0} +: WORD_W];
      end else if (wr_grant && wr_line == buf_tag) begin
        buf_valid <= 1'b0;
      end

      if (fetch_grant)
        wr_streak <= '0;
      else if (wr_grant && state == IDLE && bus.fetch_valid &&
               wr_streak != STREAK_W'(STARVE_LIMIT))
        wr_streak <= wr_streak + STREAK_W'(1);

      if (wr_grant) begin
        last_addr <= wr_line;
        last_data <= bus.wr_data;
      end else if (fetch_wins) begin
        last_addr <= fetch_line;
      end
    end
  end
endmodule
